// File: rtl/dma_ahb_master.sv
// AHB3-Lite burst master for the DMA: takes one arbiter grant and runs a single
// SINGLE/INCR4/8/16 burst for that stream, moving data between the bus and the stream FIFO.
module dma_ahb_master #(
  parameter int unsigned numb_ch = 8
) (
  input  logic                       i_clk,
  input  logic                       i_nreset,
  input  logic                       i_master_en,
  input  logic [$clog2(numb_ch)-1:0] i_stream_sel,
  input  logic [31:0]                i_addr  [numb_ch],
  input  logic [1:0]                 i_size  [numb_ch],
  input  logic [1:0]                 i_burst [numb_ch],
  input  logic                       i_write [numb_ch],
  input  logic [31:0]                i_fifo_rdata,
  output logic                       o_fifo_pop,
  output logic                       o_fifo_push,
  output logic [31:0]                o_fifo_wdata,
  output logic                       o_beat_done,
  output logic [$clog2(numb_ch)-1:0] o_active_stream,
  output logic                       o_error,
  output logic                       o_master_ready,
  output logic [31:0]                o_haddr,
  output logic [1:0]                 o_htrans,
  output logic                       o_hwrite,
  output logic [2:0]                 o_hsize,
  output logic [2:0]                 o_hburst,
  output logic [31:0]                o_hwdata,
  input  logic [31:0]                i_hrdata,
  input  logic                       i_hready,
  input  logic                       i_hresp
);

  localparam int unsigned SEL_W = $clog2(numb_ch);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_t;

  state_t           state_q,  state_d;
  htrans_t          htrans_q, htrans_d;
  logic [31:0]      haddr_q,  haddr_d;
  logic             hwrite_q, hwrite_d;
  logic [2:0]       hsize_q,  hsize_d;
  logic [2:0]       hburst_q, hburst_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic [SEL_W-1:0] stream_q, stream_d;
  logic [3:0]       left_q,   left_d;

  logic        bus_err;
  logic        err_det;
  logic        in_aphase;
  logic        in_dphase;
  logic        aph_accept;
  logic        beat_ok;
  logic [31:0] step;

  function automatic logic [3:0] beats_minus_one(input logic [1:0] burst);
    case (burst)
      2'd0:    return 4'd0;
      2'd1:    return 4'd3;
      2'd2:    return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [2:0] hburst_code(input logic [1:0] burst);
    case (burst)
      2'd0:    return 3'b000;
      2'd1:    return 3'b011;
      2'd2:    return 3'b101;
      default: return 3'b111;
    endcase
  endfunction

  // ADDR/BURST present an address phase; BURST/LAST own an outstanding data phase.
  assign in_aphase  = (state_q == S_ADDR) || (state_q == S_BURST);
  assign in_dphase  = (state_q == S_BURST) || (state_q == S_LAST);
  assign bus_err    = !i_hready && i_hresp;
  assign err_det    = bus_err && (in_aphase || in_dphase);
  assign aph_accept = in_aphase && i_hready;
  assign beat_ok    = in_dphase && i_hready && !i_hresp;
  assign step       = 32'd1 << hsize_q[1:0];

  assign o_fifo_pop      = aph_accept && hwrite_q;
  assign o_beat_done     = beat_ok;
  assign o_fifo_push     = beat_ok && !hwrite_q;
  assign o_fifo_wdata    = o_fifo_push ? i_hrdata : '0;
  assign o_error         = (state_q == S_ERR);
  assign o_master_ready  = (state_q == S_IDLE);
  assign o_htrans        = htrans_q;
  assign o_haddr         = haddr_q;
  assign o_hwrite        = hwrite_q;
  assign o_hsize         = hsize_q;
  assign o_hburst        = hburst_q;
  assign o_hwdata        = hwdata_q;
  assign o_active_stream = stream_q;

  always_comb begin
    state_d  = state_q;
    htrans_d = htrans_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hburst_d = hburst_q;
    hwdata_d = hwdata_q;
    stream_d = stream_q;
    left_d   = left_q;

    case (state_q)
      S_IDLE: begin
        if (i_master_en) begin
          stream_d = i_stream_sel;
          haddr_d  = i_addr[i_stream_sel];
          hsize_d  = {1'b0, i_size[i_stream_sel]};
          hburst_d = hburst_code(i_burst[i_stream_sel]);
          hwrite_d = i_write[i_stream_sel];
          left_d   = beats_minus_one(i_burst[i_stream_sel]);
          htrans_d = HT_NONSEQ;
          state_d  = S_ADDR;
        end
      end

      S_ADDR, S_BURST: begin
        if (err_det) begin
          htrans_d = HT_IDLE;
          state_d  = S_ERR;
        end else if (i_hready) begin
          // Write data is captured at address acceptance so it is stable for the whole data phase.
          if (hwrite_q) begin
            hwdata_d = i_fifo_rdata;
          end
          if (left_q == 4'd0) begin
            htrans_d = HT_IDLE;
            state_d  = S_LAST;
          end else begin
            left_d   = left_q - 4'd1;
            haddr_d  = haddr_q + step;
            htrans_d = HT_SEQ;
            state_d  = S_BURST;
          end
        end
      end

      S_LAST: begin
        if (err_det) begin
          htrans_d = HT_IDLE;
          state_d  = S_ERR;
        end else if (i_hready) begin
          state_d = S_IDLE;
        end
      end

      S_ERR: begin
        htrans_d = HT_IDLE;
        state_d  = S_IDLE;
      end

      default: begin
        htrans_d = HT_IDLE;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q  <= S_IDLE;
      htrans_q <= HT_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hburst_q <= '0;
      hwdata_q <= '0;
      stream_q <= '0;
      left_q   <= '0;
    end else begin
      state_q  <= state_d;
      htrans_q <= htrans_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hburst_q <= hburst_d;
      hwdata_q <= hwdata_d;
      stream_q <= stream_d;
      left_q   <= left_d;
    end
  end

endmodule

// File: tb/tb_dma_ahb_master.sv
// Scoreboard bench for dma_ahb_master: an AHB slave model with programmable wait/error
// beats and a FIFO model feed the DUT; expected bus/FIFO traffic is queued per scenario.
module tb_dma_ahb_master;

  logic        clk;
  logic        nreset;
  logic        master_en;
  logic [2:0]  stream_sel;
  logic [31:0] cfg_addr  [8];
  logic [1:0]  cfg_size  [8];
  logic [1:0]  cfg_burst [8];
  logic        cfg_write [8];
  logic [31:0] fifo_rdata;
  logic        fifo_pop;
  logic        fifo_push;
  logic [31:0] fifo_wdata;
  logic        beat_done;
  logic [2:0]  active_stream;
  logic        error;
  logic        master_ready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  dma_ahb_master #(.numb_ch(8)) dut (
    .i_clk           (clk),
    .i_nreset        (nreset),
    .i_master_en     (master_en),
    .i_stream_sel    (stream_sel),
    .i_addr          (cfg_addr),
    .i_size          (cfg_size),
    .i_burst         (cfg_burst),
    .i_write         (cfg_write),
    .i_fifo_rdata    (fifo_rdata),
    .o_fifo_pop      (fifo_pop),
    .o_fifo_push     (fifo_push),
    .o_fifo_wdata    (fifo_wdata),
    .o_beat_done     (beat_done),
    .o_active_stream (active_stream),
    .o_error         (error),
    .o_master_ready  (master_ready),
    .o_haddr         (haddr),
    .o_htrans        (htrans),
    .o_hwrite        (hwrite),
    .o_hsize         (hsize),
    .o_hburst        (hburst),
    .o_hwdata        (hwdata),
    .i_hrdata        (hrdata),
    .i_hready        (hready),
    .i_hresp         (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: tracks the outstanding data phase and its beat number within the burst.
  int unsigned stall_beat;
  int unsigned stall_cycles;
  int unsigned err_beat;
  logic        dp_valid;
  int unsigned dp_beat;
  int unsigned beat_ctr;
  logic [31:0] dp_addr;
  int unsigned wait_cnt;
  logic        err_phase;

  assign hready = !dp_valid ? 1'b1 :
                  (err_beat != 0 && dp_beat == err_beat) ? err_phase :
                  (dp_beat == stall_beat && wait_cnt < stall_cycles) ? 1'b0 : 1'b1;
  assign hresp  = dp_valid && err_beat != 0 && dp_beat == err_beat;
  assign hrdata = dp_valid ? (dp_addr ^ 32'hA5A5_0000) : 32'h0;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dp_valid  <= 1'b0;
      dp_beat   <= 0;
      beat_ctr  <= 0;
      dp_addr   <= 32'h0;
      wait_cnt  <= 0;
      err_phase <= 1'b0;
    end else if (hready) begin
      wait_cnt  <= 0;
      err_phase <= 1'b0;
      dp_valid  <= htrans[1];
      if (htrans[1]) begin
        dp_addr <= haddr;
        if (htrans == 2'b10) begin
          beat_ctr <= 1;
          dp_beat  <= 1;
        end else begin
          beat_ctr <= beat_ctr + 1;
          dp_beat  <= beat_ctr + 1;
        end
      end
    end else begin
      wait_cnt  <= wait_cnt + 1;
      err_phase <= 1'b1;
    end
  end

  logic [31:0] fifo_mem [64];
  logic [5:0]  rd_idx;
  assign fifo_rdata = fifo_mem[rd_idx];

  always @(posedge clk or negedge nreset) begin
    if (!nreset) rd_idx <= 6'd0;
    else if (fifo_pop) rd_idx <= rd_idx + 6'd1;
  end

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic        write;
    logic [2:0]  stream;
  } aph_t;

  aph_t        exp_aph   [$];
  logic [31:0] exp_push  [$];
  logic [31:0] exp_wdata [$];
  logic [31:0] burst_words [16];

  int checks;
  int errors;
  int beats_seen;
  int pushes_seen;
  int pops_seen;
  int err_seen;

  task automatic score();
    aph_t        e;
    logic [31:0] w;
    if (!nreset) return;
    if (htrans[1] && hready) begin
      checks++;
      if (exp_aph.size() == 0) begin
        errors++;
        $display("FAIL aphase_unexpected: got addr=%h trans=%0d, required no transfer", haddr, htrans);
      end else begin
        e = exp_aph.pop_front();
        if (haddr !== e.addr || htrans !== e.trans || hsize !== e.size || hburst !== e.burst ||
            hwrite !== e.write || active_stream !== e.stream || fifo_pop !== e.write) begin
          errors++;
          $display("FAIL aphase: got addr=%h trans=%0d size=%0d burst=%0d wr=%0b strm=%0d pop=%0b, required addr=%h trans=%0d size=%0d burst=%0d wr=%0b strm=%0d pop=%0b",
                   haddr, htrans, hsize, hburst, hwrite, active_stream, fifo_pop,
                   e.addr, e.trans, e.size, e.burst, e.write, e.stream, e.write);
        end
      end
    end
    if (beat_done) begin
      beats_seen++;
      if (hwrite) begin
        checks++;
        if (exp_wdata.size() == 0) begin
          errors++;
          $display("FAIL hwdata_unexpected: got %h, required no write beat", hwdata);
        end else begin
          w = exp_wdata.pop_front();
          if (hwdata !== w) begin
            errors++;
            $display("FAIL hwdata: got %h, required %h", hwdata, w);
          end
        end
      end
    end
    if (fifo_push) begin
      pushes_seen++;
      checks++;
      if (exp_push.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got %h, required no push", fifo_wdata);
      end else begin
        w = exp_push.pop_front();
        if (fifo_wdata !== w) begin
          errors++;
          $display("FAIL push_data: got %h, required %h", fifo_wdata, w);
        end
      end
    end
    if (fifo_pop) pops_seen++;
    if (error) err_seen++;
  endtask

  task automatic tick();
    @(negedge clk);
    score();
  endtask

  task automatic expect_burst(input int ch, input logic [31:0] a, input logic [1:0] sz,
                              input logic [1:0] bu, input logic wr, input int n_aph, input int n_ok);
    aph_t        e;
    logic [31:0] ak;
    logic [2:0]  hb;
    cfg_addr[ch]  = a;
    cfg_size[ch]  = sz;
    cfg_burst[ch] = bu;
    cfg_write[ch] = wr;
    case (bu)
      2'd0:    hb = 3'b000;
      2'd1:    hb = 3'b011;
      2'd2:    hb = 3'b101;
      default: hb = 3'b111;
    endcase
    for (int k = 0; k < n_aph; k++) begin
      ak      = a + (32'(k) << sz);
      e.addr  = ak;
      e.trans = (k == 0) ? 2'b10 : 2'b11;
      e.size  = {1'b0, sz};
      e.burst = hb;
      e.write = wr;
      e.stream = 3'(ch);
      exp_aph.push_back(e);
      if (wr) begin
        burst_words[k] = $urandom;
        fifo_mem[rd_idx + 6'(k)] = burst_words[k];
        if (k < n_ok) exp_wdata.push_back(burst_words[k]);
      end else if (k < n_ok) begin
        exp_push.push_back(ak ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic launch(input int ch);
    stream_sel = 3'(ch);
    master_en  = 1'b1;
    tick();
    master_en  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!master_ready && cycles < budget) begin
      tick();
      cycles++;
    end
    checks++;
    if (master_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: ready=%b after %0d cycles, required 1", name, master_ready, cycles);
    end
  endtask

  task automatic check_queues(input string name);
    checks++;
    if (exp_aph.size() != 0 || exp_push.size() != 0 || exp_wdata.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: aph=%0d push=%0d wdata=%0d outstanding, required 0 0 0",
               name, exp_aph.size(), exp_push.size(), exp_wdata.size());
    end
  endtask

  task automatic check_count(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 || hsize !== 3'b000 ||
        hburst !== 3'b000 || hwdata !== 32'h0 || fifo_wdata !== 32'h0 || active_stream !== 3'd0) begin
      errors++;
      $display("FAIL %s_bus: got trans=%0d addr=%h wr=%b size=%0d burst=%0d wdata=%h fwdata=%h strm=%0d, required all 0",
               name, htrans, haddr, hwrite, hsize, hburst, hwdata, fifo_wdata, active_stream);
    end
    checks++;
    if (master_ready !== 1'b1 || error !== 1'b0 || fifo_pop !== 1'b0 || fifo_push !== 1'b0 || beat_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got ready=%b err=%b pop=%b push=%b done=%b, required 1 0 0 0 0",
               name, master_ready, error, fifo_pop, fifo_push, beat_done);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    #1 nreset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int b0, p0, cyc;
    b0 = beats_seen;
    p0 = pops_seen;
    expect_burst(0, 32'h0000_1000, 2'd2, 2'd0, 1'b1, 1, 1);
    launch(0);
    wait_idle("single", 20, cyc);
    check_count("single_ready_latency", cyc + 1, 3);
    check_count("single_beats", beats_seen - b0, 1);
    check_count("single_pops", pops_seen - p0, 1);
    check_queues("single");
  endtask

  task automatic test_inc4_read();
    int b0, q0, cyc;
    b0 = beats_seen;
    q0 = pushes_seen;
    expect_burst(1, 32'h0000_2000, 2'd1, 2'd1, 1'b0, 4, 4);
    launch(1);
    wait_idle("inc4", 30, cyc);
    check_count("inc4_beats", beats_seen - b0, 4);
    check_count("inc4_pushes", pushes_seen - q0, 4);
    check_queues("inc4");
  endtask

  task automatic test_inc8_stall_write();
    int b0, p0, stalls, cyc;
    b0 = beats_seen;
    p0 = pops_seen;
    stalls = 0;
    stall_beat   = 3;
    stall_cycles = 2;
    expect_burst(3, 32'h0000_3000, 2'd2, 2'd2, 1'b1, 8, 8);
    launch(3);
    cyc = 0;
    while (!master_ready && cyc < 60) begin
      if (!hready) begin
        stalls++;
        checks++;
        if (haddr !== 32'h0000_300C || htrans !== 2'b11 || hwdata !== burst_words[2]) begin
          errors++;
          $display("FAIL inc8_hold: got addr=%h trans=%0d wdata=%h, required addr=0000300c trans=3 wdata=%h",
                   haddr, htrans, hwdata, burst_words[2]);
        end
      end
      tick();
      cyc++;
    end
    wait_idle("inc8", 5, cyc);
    stall_beat   = 0;
    stall_cycles = 0;
    check_count("inc8_stall_cycles", stalls, 2);
    check_count("inc8_beats", beats_seen - b0, 8);
    check_count("inc8_pops", pops_seen - p0, 8);
    check_queues("inc8");
  endtask

  task automatic test_inc16_read_error();
    int b0, q0, e0, resp_cycles, cyc;
    b0 = beats_seen;
    q0 = pushes_seen;
    e0 = err_seen;
    resp_cycles = 0;
    err_beat = 5;
    expect_burst(4, 32'h0000_4000, 2'd2, 2'd3, 1'b0, 5, 4);
    launch(4);
    cyc = 0;
    while (!master_ready && cyc < 60) begin
      if (hresp) resp_cycles++;
      if (error) begin
        checks++;
        if (htrans !== 2'b00) begin
          errors++;
          $display("FAIL err_htrans: got %0d, required 0", htrans);
        end
      end
      tick();
      cyc++;
    end
    wait_idle("inc16err", 5, cyc);
    err_beat = 0;
    check_count("err_resp_cycles", resp_cycles, 2);
    check_count("err_pulses", err_seen - e0, 1);
    check_count("err_beats", beats_seen - b0, 4);
    check_count("err_pushes", pushes_seen - q0, 4);
    check_queues("inc16err");
  endtask

  task automatic test_stream_switch();
    int cyc;
    cfg_addr[5]  = 32'h0000_9000;
    cfg_size[5]  = 2'd0;
    cfg_burst[5] = 2'd3;
    cfg_write[5] = 1'b0;
    expect_burst(2, 32'h0000_5000, 2'd2, 2'd1, 1'b1, 4, 4);
    launch(2);
    for (int i = 0; i < 3; i++) begin
      stream_sel = (i % 2 == 0) ? 3'd5 : 3'd2;
      master_en  = 1'b1;
      tick();
      checks++;
      if (active_stream !== 3'd2) begin
        errors++;
        $display("FAIL switch_active: got %0d, required 2", active_stream);
      end
    end
    master_en  = 1'b0;
    stream_sel = 3'd5;
    wait_idle("switch", 20, cyc);
    check_count("switch_active_after", int'(active_stream), 2);
    check_queues("switch");
  endtask

  task automatic test_back_to_back();
    int b0, nonseq_seen, ready_gap, cyc;
    b0 = beats_seen;
    nonseq_seen = 0;
    ready_gap = 0;
    expect_burst(6, 32'h0000_6000, 2'd2, 2'd0, 1'b0, 1, 1);
    expect_burst(6, 32'h0000_6000, 2'd2, 2'd0, 1'b0, 1, 1);
    stream_sel = 3'd6;
    master_en  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (htrans == 2'b10) begin
        nonseq_seen++;
        if (nonseq_seen == 2) break;
      end else if (nonseq_seen == 1 && master_ready) begin
        ready_gap++;
      end
    end
    master_en = 1'b0;
    wait_idle("b2b", 20, cyc);
    check_count("b2b_nonseq", nonseq_seen, 2);
    check_count("b2b_idle_gap", ready_gap, 1);
    check_count("b2b_beats", beats_seen - b0, 2);
    check_queues("b2b");
  endtask

  task automatic test_reset_mid_burst();
    int  cyc;
    bit  found;
    found = 1'b0;
    expect_burst(7, 32'h0000_7000, 2'd2, 2'd1, 1'b1, 3, 2);
    launch(7);
    for (cyc = 0; cyc < 20; cyc++) begin
      if (htrans == 2'b11 && haddr == 32'h0000_7008) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_beat3: got no beat-3 address phase, required addr 00007008 SEQ");
    end
    #2 nreset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check_queues("midrst");
    exp_aph.delete();
    exp_push.delete();
    exp_wdata.delete();
    @(negedge clk);
    nreset = 1'b1;
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    beats_seen   = 0;
    pushes_seen  = 0;
    pops_seen    = 0;
    err_seen     = 0;
    stall_beat   = 0;
    stall_cycles = 0;
    err_beat     = 0;
    master_en    = 1'b0;
    stream_sel   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cfg_addr[i]  = 32'h0;
      cfg_size[i]  = 2'd0;
      cfg_burst[i] = 2'd0;
      cfg_write[i] = 1'b0;
    end
    for (int i = 0; i < 64; i++) fifo_mem[i] = 32'h0;

    test_reset();
    test_single_write();
    test_inc4_read();
    test_inc8_stall_write();
    test_inc16_read_error();
    test_stream_switch();
    test_back_to_back();
    test_reset_mid_burst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
